id_exe_stage_reg: RTL and testbench
===================================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the ID and EXE stages of the 5-stage ARM core.
- Latches decoded control, operand values and register addresses from ID.
- Supplies EXE_src1/EXE_src2 and the destination/control fields consumed by the forwarding unit and the EXE operand muxes.
- Implements stall (freeze), branch flush, bubble insertion and valid tracking, so downstream units never forward from or for a dead instruction.

Parameters:
- WORD_LEN, 32, datapath width of PC and operand values.
- REG_ADDRESS_LEN, 4, register-file address width.
- EXE_CMD_LEN, 4, ALU command width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- freeze  in  1  hold all registered contents (load-use or memory stall).
- flush  in  1  branch taken in EXE; kill the instruction being captured.
- bubble  in  1  insert a NOP (hazard unit stall without forwarding).
- ID_valid  in  1  ID holds a real instruction.
- ID_pc  in  WORD_LEN  PC+4 of the ID instruction.
- ID_val_rn, ID_val_rm  in  WORD_LEN  register-file read data.
- ID_src1, ID_src2, ID_dst  in  REG_ADDRESS_LEN  Rn, Rm/Rd-source and destination addresses.
- ID_exe_cmd  in  EXE_CMD_LEN  ALU operation.
- ID_mem_r_en, ID_mem_w_en, ID_wb_en, ID_b, ID_s, ID_imm  in  1 each  control bits.
- ID_shift_operand  in  12  shifter operand field.
- ID_signed_imm_24  in  24  branch offset.
- ID_status  in  4  NZCV flags sampled in ID.
- EXE_* (one output per ID_* input above, same widths)  out  registered copies.
- EXE_valid  out  1  EXE holds a live instruction.
- EXE_two_src  out  1  registered (~ID_imm | ID_mem_w_en); tells the hazard unit src2 is actually read.
- bubble_count  out  8  saturating count of bubbles/flushes since reset (perf counter).

Behaviour:
- Reset (rst=0, asynchronous): every EXE_* output and EXE_valid go to 0, EXE_two_src goes to 0, bubble_count goes to 0. Effect is immediate, regardless of clk. Release is synchronous to the next rising edge.
- Priority on each rising edge: flush > bubble > freeze > normal capture.
- Normal (no flush/bubble/freeze):
  - All EXE_* outputs take the ID_* values.
  - EXE_valid takes ID_valid.
  - Latency is exactly one cycle.
- Freeze:
  - All outputs hold their values, including EXE_valid.
  - bubble_count holds.
- Bubble (freeze ignored):
  - EXE_wb_en, EXE_mem_r_en, EXE_mem_w_en, EXE_b, EXE_s and EXE_valid go to 0.
  - Data and address fields may capture ID values but must not be relied on.
  - bubble_count increments.
- Flush: same as bubble. Flush together with bubble counts once.
- Invalid instruction (ID_valid=0 in the normal case):
  - Captured as a NOP.
  - Control enables are forced to 0 as for a bubble.
  - bubble_count does not increment.
- Invariant: EXE_wb_en=1 implies EXE_valid=1. The same holds for mem_r_en, mem_w_en, b and s. Bench must assert this every cycle.
- bubble_count saturates at 255; it never wraps.
- Outputs are pure registers: no combinational path from any input to any output.
- No internal FSM beyond the valid/bubble state. freeze and flush may be asserted for an arbitrary number of consecutive cycles.

Test Plan:
- Reset mid-stream: drive ID_wb_en=1, ID_dst=4'h5, ID_valid=1, and assert rst low between clock edges -> EXE_wb_en=0, EXE_valid=0, EXE_dst=0, bubble_count=0 immediately; first edge after release captures the ID values.
- Normal pipe: ID_val_rn=32'h0000_00AA, ID_src1=4'h3, ID_exe_cmd=4'b0010, ID_wb_en=1 -> one edge later EXE_val_rn=32'h0000_00AA, EXE_src1=3, EXE_exe_cmd=4'b0010, EXE_wb_en=1, EXE_valid=1.
- Freeze 3 cycles while the ID inputs change -> EXE outputs unchanged for 3 edges; the edge after freeze drops captures the current ID values.
- Flush and freeze asserted together with ID_mem_w_en=1, ID_valid=1 -> EXE_mem_w_en=0, EXE_valid=0, bubble_count increments by exactly 1.
- Bubble held for 300 cycles -> bubble_count saturates at 255 and stays there; enables stay 0 throughout.
- ID_imm=1, ID_mem_w_en=0 -> EXE_two_src=0. ID_imm=1, ID_mem_w_en=1 -> EXE_two_src=1. ID_valid=0 with ID_wb_en=1 -> EXE_wb_en=0 and bubble_count unchanged.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register for the 5-stage ARM core: captures decoded fields,
// handles freeze/flush/bubble, tracks instruction validity and counts bubbles.
module id_exe_stage_reg #(
    parameter int WORD_LEN        = 32,
    parameter int REG_ADDRESS_LEN = 4,
    parameter int EXE_CMD_LEN     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       freeze,
    input  logic                       flush,
    input  logic                       bubble,
    input  logic                       ID_valid,
    input  logic [WORD_LEN-1:0]        ID_pc,
    input  logic [WORD_LEN-1:0]        ID_val_rn,
    input  logic [WORD_LEN-1:0]        ID_val_rm,
    input  logic [REG_ADDRESS_LEN-1:0] ID_src1,
    input  logic [REG_ADDRESS_LEN-1:0] ID_src2,
    input  logic [REG_ADDRESS_LEN-1:0] ID_dst,
    input  logic [EXE_CMD_LEN-1:0]     ID_exe_cmd,
    input  logic                       ID_mem_r_en,
    input  logic                       ID_mem_w_en,
    input  logic                       ID_wb_en,
    input  logic                       ID_b,
    input  logic                       ID_s,
    input  logic                       ID_imm,
    input  logic [11:0]                ID_shift_operand,
    input  logic [23:0]                ID_signed_imm_24,
    input  logic [3:0]                 ID_status,
    output logic                       EXE_valid,
    output logic [WORD_LEN-1:0]        EXE_pc,
    output logic [WORD_LEN-1:0]        EXE_val_rn,
    output logic [WORD_LEN-1:0]        EXE_val_rm,
    output logic [REG_ADDRESS_LEN-1:0] EXE_src1,
    output logic [REG_ADDRESS_LEN-1:0] EXE_src2,
    output logic [REG_ADDRESS_LEN-1:0] EXE_dst,
    output logic [EXE_CMD_LEN-1:0]     EXE_exe_cmd,
    output logic                       EXE_mem_r_en,
    output logic                       EXE_mem_w_en,
    output logic                       EXE_wb_en,
    output logic                       EXE_b,
    output logic                       EXE_s,
    output logic                       EXE_imm,
    output logic [11:0]                EXE_shift_operand,
    output logic [23:0]                EXE_signed_imm_24,
    output logic [3:0]                 EXE_status,
    output logic                       EXE_two_src,
    output logic [7:0]                 bubble_count
);

    // A flush or bubble kills the slot; freeze only matters when nothing kills it.
    logic kill;
    logic load_data;

    assign kill      = flush | bubble;
    assign load_data = kill | ~freeze;

    // Data and address fields: loaded whenever the register is not frozen.
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            EXE_pc            <= '0;
            EXE_val_rn        <= '0;
            EXE_val_rm        <= '0;
            EXE_src1          <= '0;
            EXE_src2          <= '0;
            EXE_dst           <= '0;
            EXE_exe_cmd       <= '0;
            EXE_imm           <= 1'b0;
            EXE_shift_operand <= '0;
            EXE_signed_imm_24 <= '0;
            EXE_status        <= '0;
            EXE_two_src       <= 1'b0;
        end else if (load_data) begin
            EXE_pc            <= ID_pc;
            EXE_val_rn        <= ID_val_rn;
            EXE_val_rm        <= ID_val_rm;
            EXE_src1          <= ID_src1;
            EXE_src2          <= ID_src2;
            EXE_dst           <= ID_dst;
            EXE_exe_cmd       <= ID_exe_cmd;
            EXE_imm           <= ID_imm;
            EXE_shift_operand <= ID_shift_operand;
            EXE_signed_imm_24 <= ID_signed_imm_24;
            EXE_status        <= ID_status;
            EXE_two_src       <= ~ID_imm | ID_mem_w_en;
        end
    end

    // Control enables are gated by validity so a dead slot can never write back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            EXE_valid    <= 1'b0;
            EXE_mem_r_en <= 1'b0;
            EXE_mem_w_en <= 1'b0;
            EXE_wb_en    <= 1'b0;
            EXE_b        <= 1'b0;
            EXE_s        <= 1'b0;
        end else if (kill) begin
            EXE_valid    <= 1'b0;
            EXE_mem_r_en <= 1'b0;
            EXE_mem_w_en <= 1'b0;
            EXE_wb_en    <= 1'b0;
            EXE_b        <= 1'b0;
            EXE_s        <= 1'b0;
        end else if (!freeze) begin
            EXE_valid    <= ID_valid;
            EXE_mem_r_en <= ID_mem_r_en & ID_valid;
            EXE_mem_w_en <= ID_mem_w_en & ID_valid;
            EXE_wb_en    <= ID_wb_en & ID_valid;
            EXE_b        <= ID_b & ID_valid;
            EXE_s        <= ID_s & ID_valid;
        end
    end

    // Saturating perf counter: one count per killed slot, never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_count <= '0;
        end else if (kill && bubble_count != 8'hFF) begin
            bubble_count <= bubble_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed self-checking bench for id_exe_stage_reg: reset, capture, freeze,
// flush/bubble, two_src, invalid capture and counter saturation.
module tb_id_exe_stage_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, flush, bubble, ID_valid;
    logic [31:0] ID_pc, ID_val_rn, ID_val_rm;
    logic [3:0]  ID_src1, ID_src2, ID_dst, ID_exe_cmd;
    logic        ID_mem_r_en, ID_mem_w_en, ID_wb_en, ID_b, ID_s, ID_imm;
    logic [11:0] ID_shift_operand;
    logic [23:0] ID_signed_imm_24;
    logic [3:0]  ID_status;

    logic        EXE_valid;
    logic [31:0] EXE_pc, EXE_val_rn, EXE_val_rm;
    logic [3:0]  EXE_src1, EXE_src2, EXE_dst, EXE_exe_cmd;
    logic        EXE_mem_r_en, EXE_mem_w_en, EXE_wb_en, EXE_b, EXE_s, EXE_imm;
    logic [11:0] EXE_shift_operand;
    logic [23:0] EXE_signed_imm_24;
    logic [3:0]  EXE_status;
    logic        EXE_two_src;
    logic [7:0]  bubble_count;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    id_exe_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .bubble(bubble),
        .ID_valid(ID_valid), .ID_pc(ID_pc), .ID_val_rn(ID_val_rn), .ID_val_rm(ID_val_rm),
        .ID_src1(ID_src1), .ID_src2(ID_src2), .ID_dst(ID_dst), .ID_exe_cmd(ID_exe_cmd),
        .ID_mem_r_en(ID_mem_r_en), .ID_mem_w_en(ID_mem_w_en), .ID_wb_en(ID_wb_en),
        .ID_b(ID_b), .ID_s(ID_s), .ID_imm(ID_imm), .ID_shift_operand(ID_shift_operand),
        .ID_signed_imm_24(ID_signed_imm_24), .ID_status(ID_status),
        .EXE_valid(EXE_valid), .EXE_pc(EXE_pc), .EXE_val_rn(EXE_val_rn), .EXE_val_rm(EXE_val_rm),
        .EXE_src1(EXE_src1), .EXE_src2(EXE_src2), .EXE_dst(EXE_dst), .EXE_exe_cmd(EXE_exe_cmd),
        .EXE_mem_r_en(EXE_mem_r_en), .EXE_mem_w_en(EXE_mem_w_en), .EXE_wb_en(EXE_wb_en),
        .EXE_b(EXE_b), .EXE_s(EXE_s), .EXE_imm(EXE_imm), .EXE_shift_operand(EXE_shift_operand),
        .EXE_signed_imm_24(EXE_signed_imm_24), .EXE_status(EXE_status),
        .EXE_two_src(EXE_two_src), .bubble_count(bubble_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Enables may only be set on a live instruction; checked on every falling edge.
    always @(negedge clk) begin
        vectors++;
        assert (!((EXE_wb_en | EXE_mem_r_en | EXE_mem_w_en | EXE_b | EXE_s) && !EXE_valid)) else begin
            miscompares++;
            $error("FAIL invariant enables=%b%b%b%b%b valid=%b",
                   EXE_wb_en, EXE_mem_r_en, EXE_mem_w_en, EXE_b, EXE_s, EXE_valid);
        end
    end

    initial begin
        logic [7:0] exp_cnt;

        rst = 1'b0; freeze = 1'b0; flush = 1'b0; bubble = 1'b0; ID_valid = 1'b0;
        ID_pc = '0; ID_val_rn = '0; ID_val_rm = '0; ID_src1 = '0; ID_src2 = '0;
        ID_dst = '0; ID_exe_cmd = '0; ID_mem_r_en = 1'b0; ID_mem_w_en = 1'b0;
        ID_wb_en = 1'b0; ID_b = 1'b0; ID_s = 1'b0; ID_imm = 1'b0;
        ID_shift_operand = '0; ID_signed_imm_24 = '0; ID_status = '0;

        #1;
        check("reset_valid", 32'(EXE_valid), 32'd0);
        check("reset_count", 32'(bubble_count), 32'd0);
        #12 rst = 1'b1;

        // Normal capture with one-cycle latency
        ID_val_rn = 32'h0000_00AA; ID_src1 = 4'h3; ID_exe_cmd = 4'b0010;
        ID_wb_en = 1'b1; ID_valid = 1'b1; ID_dst = 4'h5; ID_pc = 32'h0000_0004;
        tick();
        check("norm_val_rn", EXE_val_rn, 32'h0000_00AA);
        check("norm_src1", 32'(EXE_src1), 32'h3);
        check("norm_cmd", 32'(EXE_exe_cmd), 32'h2);
        check("norm_wb_en", 32'(EXE_wb_en), 32'd1);
        check("norm_valid", 32'(EXE_valid), 32'd1);
        check("norm_pc", EXE_pc, 32'h4);
        check("norm_two_src", 32'(EXE_two_src), 32'd1);
        check("norm_count", 32'(bubble_count), 32'd0);

        // Asynchronous reset between edges
        #1 rst = 1'b0;
        #1;
        check("arst_wb_en", 32'(EXE_wb_en), 32'd0);
        check("arst_valid", 32'(EXE_valid), 32'd0);
        check("arst_dst", 32'(EXE_dst), 32'd0);
        check("arst_count", 32'(bubble_count), 32'd0);
        #2 rst = 1'b1;
        tick();
        check("rel_wb_en", 32'(EXE_wb_en), 32'd1);
        check("rel_dst", 32'(EXE_dst), 32'h5);
        check("rel_valid", 32'(EXE_valid), 32'd1);

        // Freeze for 3 edges while ID changes
        freeze = 1'b1;
        ID_val_rn = 32'h0000_00BB; ID_dst = 4'h7; ID_wb_en = 1'b0; ID_mem_r_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frz_val_rn", EXE_val_rn, 32'h0000_00AA);
            check("frz_dst", 32'(EXE_dst), 32'h5);
            check("frz_wb_en", 32'(EXE_wb_en), 32'd1);
            check("frz_mem_r", 32'(EXE_mem_r_en), 32'd0);
            check("frz_valid", 32'(EXE_valid), 32'd1);
        end
        freeze = 1'b0;
        tick();
        check("unfrz_val_rn", EXE_val_rn, 32'h0000_00BB);
        check("unfrz_dst", 32'(EXE_dst), 32'h7);
        check("unfrz_wb_en", 32'(EXE_wb_en), 32'd0);
        check("unfrz_mem_r", 32'(EXE_mem_r_en), 32'd1);

        // Flush overrides freeze
        flush = 1'b1; freeze = 1'b1; ID_mem_w_en = 1'b1; ID_valid = 1'b1;
        tick();
        check("flush_mem_w", 32'(EXE_mem_w_en), 32'd0);
        check("flush_mem_r", 32'(EXE_mem_r_en), 32'd0);
        check("flush_valid", 32'(EXE_valid), 32'd0);
        check("flush_count", 32'(bubble_count), 32'd1);

        // Flush and bubble together count once
        freeze = 1'b0; bubble = 1'b1;
        tick();
        check("fb_count", 32'(bubble_count), 32'd2);
        check("fb_valid", 32'(EXE_valid), 32'd0);
        flush = 1'b0; bubble = 1'b0;

        // two_src decoding
        ID_imm = 1'b1; ID_mem_w_en = 1'b0; ID_mem_r_en = 1'b0;
        tick();
        check("two_src_imm", 32'(EXE_two_src), 32'd0);
        check("imm_captured", 32'(EXE_imm), 32'd1);
        ID_mem_w_en = 1'b1;
        tick();
        check("two_src_store", 32'(EXE_two_src), 32'd1);
        check("store_mem_w", 32'(EXE_mem_w_en), 32'd1);
        check("store_count", 32'(bubble_count), 32'd2);

        // Invalid instruction is captured as a NOP without counting
        ID_valid = 1'b0; ID_wb_en = 1'b1; ID_mem_w_en = 1'b0; ID_imm = 1'b0;
        ID_b = 1'b1; ID_s = 1'b1;
        tick();
        check("inv_wb_en", 32'(EXE_wb_en), 32'd0);
        check("inv_b", 32'(EXE_b), 32'd0);
        check("inv_s", 32'(EXE_s), 32'd0);
        check("inv_valid", 32'(EXE_valid), 32'd0);
        check("inv_count", 32'(bubble_count), 32'd2);

        // Long bubble saturates the counter
        ID_valid = 1'b1; bubble = 1'b1;
        exp_cnt = 8'd2;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
            check("sat_count", 32'(bubble_count), 32'(exp_cnt));
            check("sat_wb_en", 32'(EXE_wb_en), 32'd0);
        end
        check("sat_final", 32'(bubble_count), 32'd255);

        // Freeze after a bubble holds the dead slot and the counter
        bubble = 1'b0; freeze = 1'b1;
        tick();
        check("hold_count", 32'(bubble_count), 32'd255);
        check("hold_valid", 32'(EXE_valid), 32'd0);
        freeze = 1'b0;
        tick();
        check("resume_valid", 32'(EXE_valid), 32'd1);
        check("resume_wb_en", 32'(EXE_wb_en), 32'd1);
        check("resume_b", 32'(EXE_b), 32'd1);
        check("resume_count", 32'(bubble_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
